// File: rtl/alu_ex_stage.sv
// Two-stage pipelined ALU execute block: S1 registers the operation and operands,
// S2 registers result/zero/illegal_op, with valid/ready handshakes on both sides.
module alu_ex_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal_op
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;

   logic             r_s1_valid;
   logic [3:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic             w_s1_en;
   logic             w_s2_en;
   logic [WIDTH-1:0] w_result;
   logic             w_illegal;
   logic             w_zero;

   // Handshake: a beat moves across a boundary on a rising edge where valid & ready
   // are both high; a stage advances when its successor is empty or draining, and
   // in_ready never looks at in_valid.
   assign w_s2_en  = !r_s2_valid || out_ready;
   assign w_s1_en  = !r_s1_valid || w_s2_en;
   assign in_ready = w_s1_en;

   always_comb begin
      w_result  = '0;
      w_illegal = 1'b0;
      case (r_s1_op)
         OP_AND:  w_result = r_s1_a & r_s1_b;
         OP_OR:   w_result = r_s1_a | r_s1_b;
         OP_ADD:  w_result = r_s1_a + r_s1_b;
         OP_SUB:  w_result = r_s1_a + ~r_s1_b + {{(WIDTH-1){1'b0}}, 1'b1};
         OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
         default: w_illegal = 1'b1;
      endcase
   end

   // An illegal op must never look like a taken branch, so zero is masked.
   assign w_zero = !w_illegal && (w_result == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
         end else begin
            if (w_s1_en) r_s1_valid <= in_valid;
            if (w_s2_en) r_s2_valid <= r_s1_valid;
         end
         if (w_s1_en && in_valid) begin
            r_s1_op <= Operation;
            r_s1_a  <= a;
            r_s1_b  <= b;
         end
         if (w_s2_en && r_s1_valid) begin
            r_result  <= w_result;
            r_zero    <= w_zero;
            r_illegal <= w_illegal;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign result     = r_result;
   assign zero       = r_zero;
   assign illegal_op = r_illegal;

endmodule
